alu_reg_n: RTL and testbench

ALU_REG_N -- requirements
Module: alu_reg_n

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_seq.sv | 55 +++++
 rtl/alu_reg_n.sv | 95 +++++++++
 tb/tb_alu_reg_n.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the registered ALU.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [2:0] OP_INC   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_ORXOR = 3'd3;
    localparam logic [2:0] OP_REDOR = 3'd4;
    localparam logic [2:0] OP_CAT   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_HOLD  = 3'd7;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: WIDTH cycles after start; done is high during the last iteration cycle.
// Backpressure: none; start must only be raised while idle.
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [W2-1:0]    mcand;
    logic [W2-1:0]    psum;
    logic [W2-1:0]    addend;
    logic [WIDTH-1:0] mplier;

    assign addend  = mplier[0] ? mcand : '0;
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    // Product is the sum including the final iteration, so it is valid on the done edge.
    assign product = psum + addend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            psum   <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            psum   <= '0;
            mplier <= b;
        end else if (busy) begin
            psum   <= psum + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_reg_n.sv
// Registered ALU with accumulator feedback and a multi-cycle multiply.
// Latency: 1 cycle for all ops except MUL (WIDTH cycles after acceptance).
// Backpressure: in_ready low while a multiply is in progress; requests are ignored then.
module alu_reg_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 use_acc,
    input  logic [2:0]           op,
    output logic [2*WIDTH-1:0]   result,
    output logic                 out_valid
);

    localparam int W2 = 2 * WIDTH;

    logic             state;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [W2-1:0]    mul_product;
    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [W2-1:0]    alu_res;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign bop       = use_acc ? result[WIDTH-1:0] : b;

    // Bit WIDTH of the extended difference is the borrow.
    assign sum  = {1'b0, a} + {1'b0, (op == OP_INC) ? WIDTH'(1) : bop};
    assign diff = {1'b0, a} - {1'b0, bop};

    always_comb begin
        alu_res = '0;
        case (op)
            OP_INC, OP_ADD: alu_res[WIDTH:0] = sum;
            OP_SUB:         alu_res[WIDTH:0] = diff;
            OP_ORXOR:       alu_res = {a | bop, a ^ bop};
            OP_REDOR:       alu_res[0] = |{a, bop};
            OP_CAT:         alu_res = {a, bop};
            default:        alu_res = result;
        endcase
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (bop),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            result    <= alu_res;
                            out_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (mul_done) begin
                        result    <= mul_product;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_reg_n.sv
// Directed self-checking bench for alu_reg_n at WIDTH=4.
module tb_alu_reg_n;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
    logic [2:0] op;
    logic [7:0] result;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    alu_reg_n #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .use_acc   (use_acc),
        .op        (op),
        .result    (result),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [3:0] av, input logic [3:0] bv,
                        input logic acc);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        use_acc  = acc;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        use_acc  = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        use_acc  = 1'b0;
        op       = OP_HOLD;
        #2;
        check("reset_result", result, 8'h00);
        check("reset_out_valid", {7'd0, out_valid}, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        check("ready_after_reset", {7'd0, in_ready}, 8'h01);

        // Single-cycle ops, issued back to back.
        send(OP_ADD, 4'd9, 4'd8, 1'b0);
        check("add_result", result, 8'h11);
        check("add_out_valid", {7'd0, out_valid}, 8'h01);
        send(OP_SUB, 4'd3, 4'd5, 1'b0);
        check("sub_result", result, 8'h1E);
        check("sub_out_valid", {7'd0, out_valid}, 8'h01);
        send(OP_ORXOR, 4'hA, 4'h6, 1'b0);
        check("orxor_result", result, 8'hEC);
        send(OP_CAT, 4'h3, 4'hC, 1'b0);
        check("cat_result", result, 8'h3C);
        send(OP_REDOR, 4'h0, 4'h0, 1'b0);
        check("redor_zero", result, 8'h00);
        send(OP_REDOR, 4'h0, 4'h4, 1'b0);
        check("redor_set", result, 8'h01);
        send(OP_INC, 4'hF, 4'h0, 1'b0);
        check("inc_carry", result, 8'h10);
        send(OP_SUB, 4'h7, 4'h2, 1'b0);
        check("sub_no_borrow", result, 8'h05);
        idle();
        tick();
        check("pulse_one_cycle", {7'd0, out_valid}, 8'h00);
        check("result_kept_idle", result, 8'h05);

        // Accumulator feedback and HOLD.
        send(OP_ADD, 4'd9, 4'd8, 1'b0);
        check("acc_seed", result, 8'h11);
        send(OP_ADD, 4'd2, 4'hF, 1'b1);
        check("acc_add", result, 8'h03);
        send(OP_HOLD, 4'hF, 4'hF, 1'b0);
        check("hold_result", result, 8'h03);
        check("hold_out_valid", {7'd0, out_valid}, 8'h01);
        idle();
        tick();
        check("hold_pulse_end", {7'd0, out_valid}, 8'h00);

        // MUL 15*15 with an ADD request held during the busy window.
        send(OP_MUL, 4'hF, 4'hF, 1'b0);
        check("mul_busy_0", {7'd0, in_ready}, 8'h00);
        check("mul_result_held_0", result, 8'h03);
        check("mul_no_valid_0", {7'd0, out_valid}, 8'h00);
        in_valid = 1'b1;
        op       = OP_ADD;
        a        = 4'd1;
        b        = 4'd1;
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("mul_busy_%0d", i), {7'd0, in_ready}, 8'h00);
            check($sformatf("mul_result_held_%0d", i), result, 8'h03);
            check($sformatf("mul_no_valid_%0d", i), {7'd0, out_valid}, 8'h00);
        end
        tick();
        check("mul_product", result, 8'hE1);
        check("mul_out_valid", {7'd0, out_valid}, 8'h01);
        check("mul_ready_back", {7'd0, in_ready}, 8'h01);
        tick();
        check("held_add_result", result, 8'h02);
        check("held_add_valid", {7'd0, out_valid}, 8'h01);

        // MUL with a zero operand still takes WIDTH cycles.
        send(OP_MUL, 4'h0, 4'h5, 1'b0);
        idle();
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("mulz_busy_%0d", i), {7'd0, in_ready}, 8'h00);
        end
        tick();
        check("mulz_product", result, 8'h00);
        check("mulz_out_valid", {7'd0, out_valid}, 8'h01);

        // MUL using the accumulator as operand B: 3 * 5.
        send(OP_ADD, 4'd2, 4'd3, 1'b0);
        send(OP_MUL, 4'd3, 4'hF, 1'b1);
        idle();
        for (int i = 1; i < 4; i++) tick();
        tick();
        check("mul_acc_product", result, 8'h0F);
        check("mul_acc_valid", {7'd0, out_valid}, 8'h01);

        // Reset during the second MUL cycle aborts it.
        send(OP_ADD, 4'd9, 4'd8, 1'b0);
        send(OP_MUL, 4'd2, 4'd3, 1'b0);
        idle();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("abort_result", result, 8'h00);
        check("abort_out_valid", {7'd0, out_valid}, 8'h00);
        check("abort_ready", {7'd0, in_ready}, 8'h01);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("abort_no_pulse_%0d", i), {7'd0, out_valid}, 8'h00);
        end
        check("abort_result_kept", result, 8'h00);
        send(OP_ADD, 4'd5, 4'd6, 1'b0);
        check("post_abort_add", result, 8'h0B);
        check("post_abort_valid", {7'd0, out_valid}, 8'h01);
        idle();

        // Asynchronous reset in mid-cycle from a non-zero result.
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_result", result, 8'h00);
        check("async_reset_valid", {7'd0, out_valid}, 8'h00);
        check("async_reset_ready", {7'd0, in_ready}, 8'h01);
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
